// File: rtl/image_leakyrelu_ctrl.sv
// Control sequencer for the image LeakyReLU stage: cfg latch, upstream reads,
// datapath valid tracking and credit-based downstream writes.
// Optional `LEAKY_CTRL_STALL_CNT_EN adds a saturating stall_cnt output.
module image_leakyrelu_ctrl #(
    parameter int COMPUTE_CHANNEL_OUT_NUM = 8,
    parameter int LEAKY_LATENCY           = 3,
    parameter int CNT_WIDTH               = 20,
    parameter int OUT_CREDIT              = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] cfg_beat_num,
    input  logic [7:0]           cfg_zero,
    input  logic [31:0]          cfg_temp,
    input  logic                 in_empty,
    output logic                 in_rd_en,
    output logic [7:0]           zero_data_out,
    output logic [31:0]          temp_reg_out,
    output logic                 out_wr_en,
    input  logic                 credit_ret,
    output logic                 busy,
    output logic                 done
`ifdef LEAKY_CTRL_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam logic [7:0] CREDIT_INIT = 8'(OUT_CREDIT);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

    state_t                 state;
    logic [7:0]             credit;
    logic [CNT_WIDTH-1:0]   remain;
    logic [LEAKY_LATENCY:0] vld_sr;
    logic                   lanes_unused;

    assign lanes_unused = (COMPUTE_CHANNEL_OUT_NUM > 0);

    assign in_rd_en  = (state == RUN) && !in_empty && (credit != 8'd0) && (remain != '0);
    assign out_wr_en = vld_sr[LEAKY_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
        end else begin
            vld_sr <= {vld_sr[LEAKY_LATENCY-1:0], in_rd_en};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            credit        <= '0;
            remain        <= '0;
            zero_data_out <= '0;
            temp_reg_out  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (in_rd_en && !credit_ret) begin
                credit <= credit - 8'd1;
            end else if (credit_ret && !in_rd_en && credit != CREDIT_INIT) begin
                credit <= credit + 8'd1;
            end
            if (in_rd_en) begin
                remain <= remain - CNT_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        zero_data_out <= cfg_zero;
                        temp_reg_out  <= cfg_temp;
                        credit        <= CREDIT_INIT;
                        remain        <= cfg_beat_num;
                        busy          <= 1'b1;
                        state         <= LOAD;
                    end
                end
                LOAD: begin
                    if (remain == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (in_rd_en && remain == CNT_WIDTH'(1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Only the output stage may still be set: done lands the cycle after the last write.
                    if (vld_sr[LEAKY_LATENCY-1:0] == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LEAKY_CTRL_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == RUN && remain != '0 && (in_empty || credit == 8'd0)
                     && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_image_leakyrelu_ctrl.sv
// Bench for image_leakyrelu_ctrl: directed and random layers checked every cycle
// against a timing/queue model of the sequencer.
module tb_image_leakyrelu_ctrl;

    localparam int L  = 3;
    localparam int OC = 8;
    localparam int CW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_beat_num = '0;
    logic [7:0]    cfg_zero = '0;
    logic [31:0]   cfg_temp = '0;
    logic          in_empty = 1'b1;
    logic          credit_ret = 1'b0;
    logic          in_rd_en, out_wr_en, busy, done;
    logic [7:0]    zero_data_out;
    logic [31:0]   temp_reg_out;
`ifdef LEAKY_CTRL_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    image_leakyrelu_ctrl #(
        .COMPUTE_CHANNEL_OUT_NUM(8),
        .LEAKY_LATENCY(L),
        .CNT_WIDTH(CW),
        .OUT_CREDIT(OC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cfg_beat_num(cfg_beat_num),
        .cfg_zero(cfg_zero),
        .cfg_temp(cfg_temp),
        .in_empty(in_empty),
        .in_rd_en(in_rd_en),
        .zero_data_out(zero_data_out),
        .temp_reg_out(temp_reg_out),
        .out_wr_en(out_wr_en),
        .credit_ret(credit_ret),
        .busy(busy),
        .done(done)
`ifdef LEAKY_CTRL_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;

    int          cyc = 0;
    bit          m_active = 0;
    int          m_start_c = 0, m_remain = 0, m_credit = 0, m_done_c = -1;
    logic [7:0]  m_zero = '0;
    logic [31:0] m_temp = '0;
    longint      m_stall = 0;
    int          wr_q[$];
    int          rd_cnt = 0, wr_cnt = 0, dut_done_c = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock cycle: compare at negedge, advance the model, then cross the posedge.
    task automatic step();
        bit e_rd, e_wr, e_done, e_busy;
        @(negedge clk);
        e_rd   = m_active && cyc >= m_start_c + 2 && m_remain > 0 && !in_empty && m_credit > 0;
        e_wr   = wr_q.size() > 0 && wr_q[0] == cyc;
        e_done = m_active && cyc == m_done_c;
        e_busy = m_active && cyc > m_start_c && cyc != m_done_c;
        chk("in_rd_en", {63'd0, in_rd_en}, {63'd0, e_rd});
        chk("out_wr_en", {63'd0, out_wr_en}, {63'd0, e_wr});
        chk("done", {63'd0, done}, {63'd0, e_done});
        chk("busy", {63'd0, busy}, {63'd0, e_busy});
        chk("zero_data_out", {56'd0, zero_data_out}, {56'd0, m_zero});
        chk("temp_reg_out", {32'd0, temp_reg_out}, {32'd0, m_temp});
`ifdef LEAKY_CTRL_STALL_CNT_EN
        chk("stall_cnt", {32'd0, stall_cnt}, {32'd0, 32'(m_stall)});
`endif
        if (in_rd_en === 1'b1) rd_cnt++;
        if (out_wr_en === 1'b1) wr_cnt++;
        if (done === 1'b1) dut_done_c = cyc;

        if (rst) begin
            m_active = 0; m_remain = 0; m_credit = 0; m_done_c = -1;
            m_zero = '0; m_temp = '0; m_stall = 0;
            wr_q.delete();
        end else begin
            if (m_active && cyc >= m_start_c + 2 && m_remain > 0 && (in_empty || m_credit == 0)
                && m_stall < 64'hFFFF_FFFF)
                m_stall++;
            if (e_wr) void'(wr_q.pop_front());
            if (e_rd) begin
                m_remain--;
                wr_q.push_back(cyc + L + 1);
                if (m_remain == 0) m_done_c = cyc + L + 2;
            end
            if (e_rd && !credit_ret) m_credit--;
            else if (credit_ret && !e_rd && m_credit < OC) m_credit++;
            if (start && !m_active) begin
                m_active  = 1;
                m_start_c = cyc;
                m_remain  = int'(cfg_beat_num);
                m_credit  = OC;
                m_zero    = cfg_zero;
                m_temp    = cfg_temp;
                m_stall   = 0;
                m_done_c  = (cfg_beat_num == '0) ? cyc + 2 : -1;
            end else if (e_done) begin
                m_active = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_start(input int beats, input logic [7:0] z, input logic [31:0] t);
        rd_cnt = 0; wr_cnt = 0; dut_done_c = -1;
        cfg_beat_num = CW'(beats);
        cfg_zero = z;
        cfg_temp = t;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_idle(input int budget);
        for (int i = 0; i < budget && m_active; i++) step();
        step();
        chk("layer_end_busy", {63'd0, busy}, 64'd0);
    endtask

    int          t0;
    logic [7:0]  z0;
    logic [31:0] tp0;

    initial begin
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;
        step();

        // 16-beat layer, credits returned from the first write onward
        in_empty = 1'b0;
        t0 = cyc;
        do_start(16, 8'($urandom), $urandom);
        for (int i = 0; i < 30; i++) begin
            credit_ret = (cyc >= t0 + 6);
            step();
        end
        credit_ret = 1'b0;
        chk("t1_reads", 64'(rd_cnt), 64'd16);
        chk("t1_writes", 64'(wr_cnt), 64'd16);
        chk("t1_done_cycle", 64'(dut_done_c), 64'(t0 + 22));

        // credit exhaustion then four returns
        do_start(12, 8'h11, 32'hCAFE_0001);
        for (int i = 0; i < 20; i++) step();
        chk("t2_reads_at_stall", 64'(rd_cnt), 64'd8);
        credit_ret = 1'b1;
        for (int i = 0; i < 4; i++) step();
        credit_ret = 1'b0;
        run_idle(40);
        chk("t2_reads", 64'(rd_cnt), 64'd12);
        chk("t2_writes", 64'(wr_cnt), 64'd12);
        chk("t2_done_seen", {63'd0, dut_done_c >= 0}, 64'd1);

        // upstream empty toggling
        do_start(5, 8'h22, 32'h0BAD_BEEF);
        for (int i = 0; i < 30; i++) begin
            in_empty = (cyc % 2 == 0);
            step();
        end
        in_empty = 1'b0;
        chk("t3_writes", 64'(wr_cnt), 64'd5);

        // zero-length layer
        t0 = cyc;
        do_start(0, 8'h80, 32'h1234_5678);
        for (int i = 0; i < 6; i++) step();
        chk("t4_done_cycle", 64'(dut_done_c), 64'(t0 + 2));
        chk("t4_reads", 64'(rd_cnt), 64'd0);
        chk("t4_zero_hold", {56'd0, zero_data_out}, 64'h80);
        chk("t4_temp_hold", {32'd0, temp_reg_out}, 64'h1234_5678);

        // ignored restart, then reset at the third read
        z0 = 8'($urandom); tp0 = $urandom;
        do_start(10, z0, tp0);
        step();
        step();
        cfg_zero = ~z0; cfg_temp = ~tp0; cfg_beat_num = CW'(3);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_zero_kept", {56'd0, zero_data_out}, {56'd0, z0});
        chk("t5_temp_kept", {32'd0, temp_reg_out}, {32'd0, tp0});
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_reads_before_rst", 64'(rd_cnt), 64'd3);
        step();
        chk("t5_rst_outputs", {in_rd_en, out_wr_en, busy, done, zero_data_out, temp_reg_out}, 64'd0);
        for (int i = 0; i < 10; i++) step();
        chk("t5_no_done", 64'(dut_done_c), -64'sd1);
        do_start(4, 8'h5A, 32'h0000_A5A5);
        run_idle(40);
        chk("t5_fresh_writes", 64'(wr_cnt), 64'd4);

        // random layers with random backpressure and stray starts
        for (int n = 0; n < 8; n++) begin
            do_start(int'($urandom_range(0, 20)), 8'($urandom), $urandom);
            for (int i = 0; i < 300 && m_active; i++) begin
                in_empty   = ($urandom_range(0, 3) == 0);
                credit_ret = ($urandom_range(0, 1) == 1);
                start      = ($urandom_range(0, 9) == 0);
                cfg_zero   = 8'($urandom);
                cfg_temp   = $urandom;
                step();
            end
            start = 1'b0; credit_ret = 1'b0; in_empty = 1'b0;
            run_idle(20);
        end

`ifdef LEAKY_CTRL_STALL_CNT_EN
        // three empty stalls, then three no-credit stalls in a 10-beat layer
        t0 = cyc;
        do_start(10, 8'h01, 32'h0000_0002);
        for (int i = 0; i < 30; i++) begin
            in_empty   = (cyc >= t0 + 2 && cyc <= t0 + 4);
            credit_ret = (cyc >= t0 + 15);
            step();
        end
        credit_ret = 1'b0; in_empty = 1'b0;
        chk("stall_total", {32'd0, stall_cnt}, 64'd6);
        chk("stall_writes", 64'(wr_cnt), 64'd10);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
